// File: rtl/rsa_msg_sequencer.sv
// rsa_msg_sequencer
//   Control stage in front of a modular-exponentiation core. Holds a
//   key/modulus/latency configuration, accepts one plaintext word at a time,
//   runs the core for a programmed number of cycles and hands the captured
//   result downstream. Words whose base is not below the modulus skip the
//   core and come back flagged as errors.
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   cfg_load/cfg_key/cfg_n/cfg_lat, cfg_ok   configuration load (IDLE only)
//   in_valid/in_ready/in_data    plaintext handshake
//   core_start                   core active-low clear (0 = held clear)
//   core_key/core_n/core_base    registered operands to the core
//   core_result                  core output, sampled on the last RUN edge
//   out_valid/out_ready/out_data/out_err   result handshake
//   busy                         sequencer is not idle
module rsa_msg_sequencer #(
  parameter int n     = 6,
  parameter int LAT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cfg_load,
  input  logic [n-1:0]     cfg_key,
  input  logic [n-1:0]     cfg_n,
  input  logic [LAT_W-1:0] cfg_lat,
  output logic             cfg_ok,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [n-1:0]     in_data,
  output logic             core_start,
  output logic [n-1:0]     core_key,
  output logic [n-1:0]     core_n,
  output logic [n-1:0]     core_base,
  input  logic [n-1:0]     core_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [n-1:0]     out_data,
  output logic             out_err,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, HOLD} state_t;

  localparam logic [n-1:0]     MIN_MOD = n'(2);
  localparam logic [LAT_W-1:0] LAT_ONE = LAT_W'(1);

  state_t           state_reg, state_next;
  logic [LAT_W-1:0] lat_reg, lat_next;
  logic [LAT_W-1:0] cnt_reg, cnt_next;
  logic [n-1:0]     key_reg, key_next;
  logic [n-1:0]     mod_reg, mod_next;
  logic [n-1:0]     base_reg, base_next;
  logic [n-1:0]     data_reg, data_next;
  logic             cfg_ok_reg, cfg_ok_next;
  logic             valid_reg, valid_next;
  logic             err_reg, err_next;
  logic             start_reg, start_next;
  logic             busy_reg, busy_next;
  logic             accept;

  // A configuration load in the same cycle wins over an offered word.
  assign in_ready = (state_reg == IDLE) & cfg_ok_reg & ~cfg_load;
  assign accept   = in_valid & in_ready;

  assign cfg_ok     = cfg_ok_reg;
  assign core_key   = key_reg;
  assign core_n     = mod_reg;
  assign core_base  = base_reg;
  assign core_start = start_reg;
  assign out_valid  = valid_reg;
  assign out_data   = data_reg;
  assign out_err    = err_reg;
  assign busy       = busy_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      lat_reg    <= '0;
      cnt_reg    <= '0;
      key_reg    <= '0;
      mod_reg    <= '0;
      base_reg   <= '0;
      data_reg   <= '0;
      cfg_ok_reg <= 1'b0;
      valid_reg  <= 1'b0;
      err_reg    <= 1'b0;
      start_reg  <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      lat_reg    <= lat_next;
      cnt_reg    <= cnt_next;
      key_reg    <= key_next;
      mod_reg    <= mod_next;
      base_reg   <= base_next;
      data_reg   <= data_next;
      cfg_ok_reg <= cfg_ok_next;
      valid_reg  <= valid_next;
      err_reg    <= err_next;
      start_reg  <= start_next;
      busy_reg   <= busy_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    lat_next    = lat_reg;
    cnt_next    = cnt_reg;
    key_next    = key_reg;
    mod_next    = mod_reg;
    base_next   = base_reg;
    data_next   = data_reg;
    cfg_ok_next = cfg_ok_reg;
    valid_next  = valid_reg;
    err_next    = err_reg;

    case (state_reg)
      IDLE: begin
        if (cfg_load) begin
          key_next    = cfg_key;
          mod_next    = cfg_n;
          // A zero latency still needs one RUN cycle so the counter never wraps.
          lat_next    = (cfg_lat == '0) ? LAT_ONE : cfg_lat;
          cfg_ok_next = (cfg_n >= MIN_MOD);
        end else if (accept) begin
          if (in_data < mod_reg) begin
            base_next  = in_data;
            state_next = CLEAR;
          end else begin
            data_next  = '0;
            err_next   = 1'b1;
            valid_next = 1'b1;
            state_next = HOLD;
          end
        end
      end
      CLEAR: begin
        cnt_next   = lat_reg;
        state_next = RUN;
      end
      RUN: begin
        if (cnt_reg == LAT_ONE) begin
          data_next  = core_result;
          err_next   = 1'b0;
          valid_next = 1'b1;
          state_next = HOLD;
        end else begin
          cnt_next = cnt_reg - LAT_ONE;
        end
      end
      HOLD: begin
        if (valid_reg & out_ready) begin
          valid_next = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // Registered from the next state so both outputs are glitch-free flops
    // that line up with the state they describe.
    start_next = (state_next == RUN);
    busy_next  = (state_next != IDLE);
  end

endmodule

// File: tb/tb_rsa_msg_sequencer.sv
`timescale 1ns/1ps
module tb_rsa_msg_sequencer;

  logic       clk;
  logic       reset_n;
  logic       cfg_load;
  logic [5:0] cfg_key, cfg_n;
  logic [7:0] cfg_lat;
  logic       cfg_ok;
  logic       in_valid, in_ready;
  logic [5:0] in_data;
  logic       core_start;
  logic [5:0] core_key, core_n, core_base, core_result;
  logic       out_valid, out_ready;
  logic [5:0] out_data;
  logic       out_err, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  rsa_msg_sequencer #(.n(6), .LAT_W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_load(cfg_load), .cfg_key(cfg_key), .cfg_n(cfg_n), .cfg_lat(cfg_lat),
    .cfg_ok(cfg_ok),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .core_start(core_start), .core_key(core_key), .core_n(core_n),
    .core_base(core_base), .core_result(core_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err(out_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int modexp(input int b, input int e, input int m);
    int r;
    if (m <= 0) return 0;
    r = 1 % m;
    for (int i = 0; i < e; i++) r = (r * b) % m;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  int m_ok, m_key, m_mod, m_lat, m_base;
  int pend, m_hs, m_L, m_byp, m_data, m_err;
  int words_done = 0;
  int p0, exp_ir, exp_cs, exp_ov;

  always @(negedge clk) begin
    if (!reset_n) begin
      m_ok = 0; m_key = 0; m_mod = 0; m_lat = 1; m_base = 0;
      pend = 0; m_L = 1; m_hs = 0; m_byp = 0;
    end else begin
      p0     = pend;
      exp_ir = (m_ok != 0 && pend == 0 && !cfg_load) ? 1 : 0;
      exp_cs = (pend != 0 && m_byp == 0 && cyc >= m_hs + 1 && cyc <= m_hs + m_L) ? 1 : 0;
      exp_ov = (pend != 0 && cyc >= (m_byp != 0 ? m_hs : m_hs + m_L + 1)) ? 1 : 0;
      chk("mon_in_ready", in_ready, exp_ir);
      chk("mon_core_start", core_start, exp_cs);
      chk("mon_out_valid", out_valid, exp_ov);
      chk("mon_busy", busy, pend);
      chk("mon_cfg_ok", cfg_ok, m_ok);
      chk("mon_core_key", core_key, m_key);
      chk("mon_core_n", core_n, m_mod);
      chk("mon_core_base", core_base, m_base);
      if (exp_ov != 0) begin
        chk("mon_out_data", out_data, m_data);
        chk("mon_out_err", out_err, m_err);
      end
      if (p0 != 0 && exp_ov != 0 && out_ready) begin
        pend = 0;
        words_done++;
      end
      if (p0 == 0 && cfg_load) begin
        m_key = cfg_key; m_mod = cfg_n;
        m_lat = (cfg_lat == 0) ? 1 : int'(cfg_lat);
        m_ok  = (cfg_n >= 2) ? 1 : 0;
      end
      if (p0 == 0 && exp_ir != 0 && in_valid) begin
        pend = 1; m_hs = cyc + 1; m_L = m_lat;
        m_byp = (int'(in_data) >= m_mod) ? 1 : 0;
        if (m_byp != 0) begin
          m_data = 0; m_err = 1;
        end else begin
          m_data = modexp(in_data, m_key, m_mod); m_err = 0; m_base = in_data;
        end
      end
    end
  end

  // Behavioural core: the result is only correct once it has run L cycles.
  int core_cnt = 0;
  always @(posedge clk) core_cnt <= core_start ? core_cnt + 1 : 0;
  always_comb begin
    core_result = '0;
    if (core_start) begin
      if (core_cnt >= m_L - 1) core_result = 6'(modexp(core_base, core_key, core_n));
      else core_result = 6'(modexp(core_base, core_key, core_n)) ^ 6'h2B;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic do_cfg(input int k, input int m, input int l);
    cfg_load = 1'b1; cfg_key = 6'(k); cfg_n = 6'(m); cfg_lat = 8'(l);
    sync();
    cfg_load = 1'b0;
  endtask

  task automatic wait_hs(output int hs);
    hs = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready && in_valid) begin hs = cyc + 1; break; end
    end
    if (hs < 0) chk("handshake_timeout", 0, 1);
  endtask

  task automatic send_word(input int b, output int hs);
    in_data = 6'(b); in_valid = 1'b1;
    wait_hs(hs);
    sync();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int d, output int e, output int vc);
    vc = -1; d = -1; e = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid) begin d = out_data; e = out_err; vc = cyc; break; end
    end
    if (vc < 0) chk("result_timeout", 0, 1);
  endtask

  typedef struct {
    int base;
    int exp;
  } stream_vec_t;

  typedef struct {
    int key; int m; int lat; int base;
    int exp_ok; int exp_data; int exp_err;
  } cfg_vec_t;

  stream_vec_t svec[8];
  cfg_vec_t    cvec[6];
  int hs, hs2, prev_hs, d, e, vc, c, cs_cnt, first_v, start_done;

  initial begin
    svec[0] = '{0, 0};  svec[1] = '{1, 1};  svec[2] = '{2, 8};  svec[3] = '{3, 27};
    svec[4] = '{4, 31}; svec[5] = '{5, 26}; svec[6] = '{6, 18}; svec[7] = '{7, 13};
    cvec[0] = '{7, 33, 10, 4, 1, 16, 0};
    cvec[1] = '{7, 33, 10, 40, 1, 0, 1};
    cvec[2] = '{3, 33, 0, 2, 1, 8, 0};
    cvec[3] = '{5, 2, 3, 1, 1, 1, 0};
    cvec[4] = '{5, 2, 3, 2, 1, 0, 1};
    cvec[5] = '{2, 63, 1, 62, 1, 1, 0};

    reset_n = 1'b0; cfg_load = 1'b0; cfg_key = '0; cfg_n = '0; cfg_lat = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) sync();
    reset_n = 1'b1;

    // Reset/idle: a word is offered but nothing may happen without a config.
    in_valid = 1'b1; in_data = 6'd5;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_outputs_zero", int'({in_ready, out_valid, out_data, out_err, core_start,
                                     core_key, core_n, core_base, cfg_ok, busy}), 0);
    end
    sync(); in_valid = 1'b0;

    // Single word: key 7, n 33, lat 10, base 4 -> 16.
    out_ready = 1'b1;
    do_cfg(7, 33, 10);
    send_word(4, hs);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) chk("single_clear_start", core_start, 0);
      else if (i <= 10) begin
        chk("single_run_start", core_start, 1);
        chk("single_no_valid_yet", out_valid, 0);
      end else begin
        chk("single_valid_at_12", out_valid, 1);
        chk("single_data", out_data, 16);
        chk("single_err", out_err, 0);
        chk("single_start_low", core_start, 0);
      end
    end
    sync();

    // Backpressure: result held for 15 cycles while a second word waits.
    out_ready = 1'b0;
    send_word(5, hs);
    wait_out(d, e, vc);
    chk("bp_first_data", d, 14);
    sync();
    in_valid = 1'b1; in_data = 6'd2;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("bp_valid_held", out_valid, 1);
      chk("bp_data_stable", out_data, 14);
      chk("bp_in_ready_low", in_ready, 0);
    end
    sync();
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_no_skid_ready", in_ready, 0);
    c = cyc;
    wait_hs(hs2);
    chk("bp_accept_after_consume", hs2 - c, 2);
    sync(); in_valid = 1'b0;
    wait_out(d, e, vc);
    chk("bp_second_data", d, 29);
    sync();

    // Range error: base 40 >= 33 bypasses the core.
    out_ready = 1'b0;
    send_word(40, hs);
    @(negedge clk);
    chk("range_valid_next_cycle", out_valid, 1);
    chk("range_err", out_err, 1);
    chk("range_data", out_data, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("range_core_idle", core_start, 0);
    end
    sync(); out_ready = 1'b1;
    sync();
    @(negedge clk);
    chk("range_back_idle", busy, 0);
    sync();

    // cfg_n = 1 is not a usable modulus.
    do_cfg(3, 1, 4);
    in_valid = 1'b1; in_data = 6'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("badmod_cfg_ok", cfg_ok, 0);
      chk("badmod_in_ready", in_ready, 0);
    end
    sync(); in_valid = 1'b0;

    // cfg_lat = 0 behaves as a one-cycle run.
    do_cfg(3, 33, 0);
    send_word(2, hs);
    cs_cnt = 0; first_v = -1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (core_start) cs_cnt++;
      if (out_valid && first_v < 0) begin first_v = cyc - hs; d = out_data; end
    end
    chk("lat0_run_cycles", cs_cnt, 1);
    chk("lat0_valid_offset", first_v, 2);
    chk("lat0_data", d, 8);
    sync();

    // cfg_load and in_valid together: config wins, word is not taken.
    cfg_load = 1'b1; cfg_key = 6'd5; cfg_n = 6'd33; cfg_lat = 8'd2;
    in_valid = 1'b1; in_data = 6'd3;
    @(negedge clk);
    chk("cfgword_in_ready", in_ready, 0);
    sync(); cfg_load = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("cfgword_not_busy", busy, 0);
    chk("cfgword_new_key", core_key, 5);
    sync();
    send_word(2, hs);
    wait_out(d, e, vc);
    chk("cfgword_result", d, 32);
    sync();

    // cfg_load during RUN is ignored.
    do_cfg(3, 33, 6);
    send_word(2, hs);
    sync(); sync();
    cfg_load = 1'b1; cfg_key = 6'd7; cfg_n = 6'd40; cfg_lat = 8'd1;
    sync(); cfg_load = 1'b0;
    wait_out(d, e, vc);
    chk("runcfg_old_key_result", d, 8);
    chk("runcfg_latency", vc - hs, 7);
    chk("runcfg_key_kept", core_key, 3);
    chk("runcfg_mod_kept", core_n, 33);
    sync();
    send_word(2, hs);
    wait_out(d, e, vc);
    chk("runcfg_next_word", d, 8);
    sync();

    // Stream of 8 back-to-back words, key 3, n 33, lat 4.
    do_cfg(3, 33, 4);
    in_valid = 1'b1; in_data = 6'(svec[0].base);
    prev_hs = 0;
    for (int i = 0; i < 8; i++) begin
      wait_hs(hs);
      if (i > 0) chk("stream_spacing", hs - prev_hs, 7);
      prev_hs = hs;
      sync();
      wait_out(d, e, vc);
      chk("stream_data", d, svec[i].exp);
      chk("stream_err", e, 0);
      sync();
      if (i < 7) in_data = 6'(svec[i + 1].base);
      else in_valid = 1'b0;
    end

    // Configuration table: one word per configuration.
    for (int i = 0; i < 6; i++) begin
      do_cfg(cvec[i].key, cvec[i].m, cvec[i].lat);
      @(negedge clk);
      chk("ctab_cfg_ok", cfg_ok, cvec[i].exp_ok);
      sync();
      send_word(cvec[i].base, hs);
      wait_out(d, e, vc);
      chk("ctab_data", d, cvec[i].exp_data);
      chk("ctab_err", e, cvec[i].exp_err);
      sync();
    end

    // Randomized traffic checked by the reference model every cycle.
    do_cfg(int'($urandom_range(0, 63)), int'($urandom_range(2, 63)), int'($urandom_range(0, 7)));
    start_done = words_done;
    for (int i = 0; i < 2500; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 6'($urandom_range(0, 63));
      out_ready = ($urandom_range(0, 3) != 0);
      cfg_load  = ($urandom_range(0, 49) == 0);
      cfg_key   = 6'($urandom_range(0, 63));
      cfg_n     = 6'($urandom_range(0, 63));
      cfg_lat   = 8'($urandom_range(0, 7));
      sync();
    end
    cfg_load = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (20) sync();
    chk("random_progress", (words_done - start_done >= 40) ? 1 : 0, 1);

    // Asynchronous reset in the middle of RUN.
    do_cfg(3, 33, 10);
    send_word(4, hs);
    sync(); sync(); sync();
    #1 reset_n = 1'b0;
    #1;
    chk("areset_outputs_zero", int'({in_ready, out_valid, out_data, out_err, core_start,
                                     core_key, core_n, core_base, busy}), 0);
    chk("areset_cfg_ok", cfg_ok, 0);
    sync(); reset_n = 1'b1;
    in_valid = 1'b1; in_data = 6'd1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("areset_needs_cfg", in_ready, 0);
    end
    sync(); in_valid = 1'b0;
    repeat (2) sync();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rsa_msg_sequencer.md
# rsa_msg_sequencer

Upstream control stage for the modular-exponentiation core. Holds a programmed key/modulus pair, accepts plaintext words one at a time over a valid/ready handshake, and runs the core once per word:

- pulses the core's active-low start/clear;
- waits a programmed number of cycles;
- captures the core's result and presents it downstream over a second valid/ready handshake.

Words with base ≥ modulus bypass the core and are returned as errors.

## Interface
- n, 6, operand width (key, base, modulus, result)
- LAT_W, 8, width of the core-latency count

- clk  in  1  single clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- cfg_load  in  1  load cfg_key/cfg_n/cfg_lat (accepted in IDLE only)
- cfg_key  in  n  exponent
- cfg_n  in  n  modulus
- cfg_lat  in  LAT_W  core run length in cycles (0 treated as 1)
- cfg_ok  out  1  a valid configuration is held
- in_valid  in  1  plaintext word available
- in_ready  out  1  sequencer accepts a word this cycle
- in_data  in  n  plaintext base
- core_start  out  1  core active-low clear/start (0 = core held clear)
- core_key, core_n, core_base  out  n each  registered operands to core
- core_result  in  n  core output
- out_valid  out  1  result word available
- out_ready  in  1  downstream accepts
- out_data  out  n  result
- out_err  out  1  qualifies out_data: base ≥ modulus, core bypassed
- busy  out  1  state ≠ IDLE

## Operation
- **Reset values:** all outputs are 0 (in_ready, out_valid, out_data, out_err, core_start, core_key, core_n, core_base, cfg_ok, busy). FSM resets to IDLE and the latency counter to 0.
- **FSM states:** IDLE, CLEAR, RUN, HOLD.
- **cfg_load in IDLE:**
  - Registers key, modulus and max(cfg_lat,1) into core_key/core_n/latency register.
  - Sets cfg_ok = 1 if cfg_n ≥ 2; otherwise cfg_ok = 0.
  - cfg_load outside IDLE is ignored; the held configuration is unchanged.
- **in_ready** = (state == IDLE) & cfg_ok & ~cfg_load. cfg_load has priority over a word in the same cycle.
- **IDLE** (core_start = 0): on in_valid & in_ready, capture in_data.
  - If in_data < core_n: core_base ← in_data, go to CLEAR.
  - If in_data ≥ core_n: out_data ← 0, out_err ← 1, out_valid ← 1, go to HOLD. The core is not started.
- **CLEAR:** core_start = 0 for exactly one cycle; load counter ← latency register; go to RUN.
- **RUN:** core_start = 1. core_base/core_key/core_n stay stable.
  - If counter == 1: out_data ← core_result, out_err ← 0, out_valid ← 1, go to HOLD.
  - Otherwise counter decrements.
- **HOLD:** core_start = 0. out_valid/out_data/out_err stay stable until out_ready. On out_valid & out_ready: out_valid ← 0, go to IDLE.
- No skid: a new word is never accepted in the cycle a result is consumed.
- **Asynchronous reset mid-operation:** an in-flight word is discarded, every output returns to its reset value, and cfg_ok clears, so reconfiguration is required.
- Comparison and counter arithmetic are unsigned. The counter never wraps: CLEAR loads a value ≥ 1.

## Timing
- Input handshake at edge t. CLEAR occupies cycle t+1. RUN occupies cycles t+2 … t+1+L, where L = max(cfg_lat,1). out_valid rises after edge t+2+L.
- The core sees core_start rise at t+2. core_result is sampled at the last RUN edge.
- Bypass path (base ≥ modulus): out_valid rises after edge t+1.
- cfg_ok updates one cycle after cfg_load. in_ready can assert the cycle after that.
- Minimum word-to-word spacing with out_ready held high: L+3 cycles.
- busy is registered from the state: high from the cycle after the input handshake until the cycle after the output handshake.

## Test plan
- **Reset/idle:**
  - Release reset_n with no cfg_load: in_ready = 0, all outputs 0 for 20 cycles.
  - Assert reset_n low asynchronously mid-RUN: outputs go to 0 immediately and cfg_ok = 0.
- **Single word:**
  - Stimulus: cfg key = 7, n = 33, lat = 10; send base 4 with a behavioural core model.
  - Required: core_start low for 1 cycle then high for 10 cycles; out_data = 16, out_err = 0; out_valid appears 12 cycles after the handshake.
- **Backpressure:**
  - Stimulus: hold out_ready = 0 for 15 cycles after the result; meanwhile offer a second word.
  - Required: out_data stays stable and in_ready = 0 throughout; the second word is accepted only after out_ready.
- **Range error:**
  - Stimulus: n = 33, send base 40.
  - Required: out_err = 1, out_data = 0, out_valid one cycle after the handshake, core_start never rises.
- **Config edges:**
  - cfg_load with cfg_n = 1: cfg_ok = 0 and in_ready stays 0.
  - cfg_lat = 0: RUN lasts exactly 1 cycle.
  - cfg_load and in_valid in the same IDLE cycle: the config is taken and the word is not accepted.
  - cfg_load during RUN: ignored, and the current result is computed with the old key.
- **Stream:**
  - Stimulus: 8 back-to-back words 0..7 with n = 33, key = 3, lat = 4, out_ready = 1.
  - Required: results 0,1,8,27,31,26,18,13, in order, each spaced 7 cycles.
